sync_memory_rtl: RTL and testbench

Single-port, synchronous, word-addressed memory with a one-cycle completion pulse. It is the storage block driven by the memory-model verification environment, which accesses it through the shared `memory_if` signal bundle. Each clock it accepts at most one write or read and acknowledges accepted accesses on `response`.

---
 rtl/sync_memory_rtl.sv | 72 +++++++
 tb/tb_sync_memory_rtl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sync_memory_rtl.sv
// sync_memory_rtl: single-port, word-addressed synchronous memory.
// One write or read is accepted per clock; accepted accesses are
// acknowledged by a one-cycle registered pulse on `response`. Reads return
// data one cycle after the request. A simultaneous write and read at the
// same address is treated as a write only.
module sync_memory_rtl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  response
);

  // One extra bit lets the limit equal 2^ADDR_WIDTH without overflowing.
  localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  response_q, response_d;
  logic                  addr_ok;
  logic                  wr_en;
  logic                  rd_en;

  // Decode the request: write has priority, out-of-range addresses are dropped.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    addr_ok    = ({1'b0, addr} < MemLimit);
    wr_en      = wr && addr_ok;
    rd_en      = rd && !wr && addr_ok;
    response_d = wr_en || rd_en;
    rdata_d    = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[addr];
    end
  end

  // Storage array: cleared on reset, written on an accepted write.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the array must read back as zero right after reset, so it is
    // built from resettable flops rather than an unreset RAM macro.
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking so a read at the same edge sees the old contents.
      mem_q[addr] <= wdata;
    end
  end

  // Output registers: read data holds between accepted reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q    <= '0;
      response_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      response_q <= response_d;
    end
  end

  assign rdata    = rdata_q;
  assign response = response_q;

endmodule

// File: tb/tb_sync_memory_rtl.sv
// Testbench for sync_memory_rtl. Stimulus tasks push the expected
// {response, rdata} for each driven cycle into a scoreboard queue; a monitor
// pops one entry after every rising edge and compares it with the outputs.
module tb_sync_memory_rtl;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        response;

  exp_t        sb_q[$];
  logic [31:0] last_rd;
  int          total;
  int          bad;

  sync_memory_rtl #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32),
    .MEM_SIZE  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .response(response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request on the falling edge and record what must follow it.
  task automatic issue(input logic w, input logic r, input logic [3:0] a,
                       input logic [31:0] d, input logic exp_resp,
                       input logic [31:0] exp_rdata);
    exp_t e;
    @(negedge clk);
    wr    = w;
    rd    = r;
    addr  = a;
    wdata = d;
    e.resp  = exp_resp;
    e.rdata = exp_rdata;
    sb_q.push_back(e);
  endtask

  task automatic wr_op(input logic [3:0] a, input logic [31:0] d);
    issue(1'b1, 1'b0, a, d, 1'b1, last_rd);
  endtask

  task automatic rd_op(input logic [3:0] a, input logic [31:0] exp);
    issue(1'b0, 1'b1, a, 32'h0, 1'b1, exp);
    last_rd = exp;
  endtask

  task automatic idle_op();
    issue(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, last_rd);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  // Monitor: compare outputs shortly after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("response", {31'h0, response}, {31'h0, e.resp});
      check("rdata", rdata, e.rdata);
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    last_rd = 32'h0;
    reset   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    addr    = 4'h0;
    wdata   = 32'h0;

    // Reset state while held and after release.
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_response", {31'h0, response}, 32'h0);
    reset = 1'b1;
    #1;
    check("release_rdata", rdata, 32'h0);
    check("release_response", {31'h0, response}, 32'h0);

    // Cleared memory reads as zero everywhere.
    for (int i = 0; i < 16; i++) rd_op(4'(i), 32'h0);

    // Write/read-back of every address.
    for (int i = 0; i < 16; i++) wr_op(4'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 16; i++) rd_op(4'(i), 32'hA5A5_0000 + 32'(i));

    // Back-to-back write then read of the new value.
    wr_op(4'd3, 32'hDEAD_BEEF);
    rd_op(4'd3, 32'hDEAD_BEEF);

    // Simultaneous write and read: write wins, rdata holds.
    wr_op(4'd5, 32'h1111_1111);
    rd_op(4'd5, 32'h1111_1111);
    issue(1'b1, 1'b1, 4'd5, 32'h2222_2222, 1'b1, 32'h1111_1111);
    rd_op(4'd5, 32'h2222_2222);

    // Idle cycles hold rdata with response low.
    wr_op(4'd9, 32'h1234_5678);
    rd_op(4'd9, 32'h1234_5678);
    repeat (5) idle_op();
    drain();

    // Reset asserted between clock edges right after an accepted write.
    wr_op(4'd7, 32'hCAFE_F00D);
    @(posedge clk);
    #3;
    check("pre_reset_response", {31'h0, response}, 32'h1);
    check("pre_reset_rdata", rdata, 32'h1234_5678);
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
    check("async_reset_response", {31'h0, response}, 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    last_rd = 32'h0;
    rd_op(4'd7, 32'h0);
    rd_op(4'd9, 32'h0);
    rd_op(4'd3, 32'h0);
    idle_op();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
